// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction-fetch front end.
//   OP_JAL / OP_BRANCH : opcodes inspected by the optional static predictor
//   NOP                : value presented on id_inst while the queue is empty
//   fetch_entry_t      : one prefetch-queue entry {inst, pc, pred_taken}
//   imm_b / imm_j      : sign-extended B-type / J-type immediates
package fetch_pkg;

  // Width of the pc field stored in a queue entry; fetch_unit XLEN must not exceed it.
  localparam int ENTRY_PC_W = 32;

  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]           inst;
    logic [ENTRY_PC_W-1:0] pc;
    logic                  pred_taken;
  } fetch_entry_t;

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch queue of fetch_entry_t, DEPTH entries (power of two).
//   clk, rst         : clock, asynchronous active-low reset
//   push, push_data  : write an entry at the tail
//   pop              : retire the head (ignored while empty)
//   flush            : discard all entries; wins over push and pop
//   head, count      : head entry (undefined while empty) and occupancy
// The caller guarantees push never targets a full queue unless a pop
// happens in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && (count != '0) && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the head is only looked at while count != 0.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end between instruction memory and ID.
//   clk, rst                      : clock, asynchronous active-low reset
//   im_req_valid/ready/addr       : fetch request port (word-aligned address)
//   im_rsp_valid/data             : in-order responses, never back-pressured
//   redirect_valid/pc             : redirect from branch resolution (highest priority)
//   id_valid/ready, id_inst, id_pc, id_pc4, id_pred_taken : queue head to decode
// Build option: define FETCH_BPRED_EN to enable static prediction (JAL and
// backward B-type predicted taken); otherwise fetch is purely sequential.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h1000_0000,
  parameter int              DEPTH     = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            im_req_valid,
  input  logic            im_req_ready,
  output logic [XLEN-1:0] im_req_addr,
  input  logic            im_rsp_valid,
  input  logic [31:0]     im_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc4,
  output logic            id_pred_taken
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;   // pc of the next response that will be kept
  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] pred_target;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   fifo_count;
  logic            req_fire;
  logic            rsp_keep;
  logic            pred_taken;
  logic [1:0]      unused_redirect_lsb;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Every in-flight request owns a queue slot, so responses always fit.
  // Gating with rst keeps the request low during reset without a cycle of delay.
  assign im_req_valid = rst && ((int'(outst_q) + int'(fifo_count)) < DEPTH);
  assign im_req_addr  = pc_q;
  assign req_fire     = im_req_valid && im_req_ready;
  assign rsp_keep     = im_rsp_valid && (drop_q == '0) && !redirect_valid;
  assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = redirect_pc[1:0];

  assign outst_d = outst_q + CW'(req_fire) - CW'(im_rsp_valid);

`ifdef FETCH_BPRED_EN
  logic [6:0] rsp_op;
  assign rsp_op      = im_rsp_data[6:0];
  assign pred_taken  = rsp_keep &&
                       ((rsp_op == OP_JAL) || ((rsp_op == OP_BRANCH) && im_rsp_data[31]));
  assign pred_target = rsp_pc_q + ((rsp_op == OP_JAL) ? XLEN'($signed(imm_j(im_rsp_data)))
                                                      : XLEN'($signed(imm_b(im_rsp_data))));
`else
  assign pred_taken  = 1'b0;
  assign pred_target = '0;
`endif

  // A redirect or prediction makes every request still in flight (including
  // one accepted this cycle) stale, so drop_cnt is reloaded from outst_d.
  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    drop_d   = drop_q;
    if (req_fire) pc_d = pc_q + XLEN'(4);
    if (rsp_keep) begin
      rsp_pc_d = rsp_pc_q + XLEN'(4);
    end else if (im_rsp_valid && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
    if (pred_taken) begin
      pc_d     = pred_target;
      rsp_pc_d = pred_target;
      drop_d   = outst_d;
    end
    if (redirect_valid) begin
      pc_d     = redirect_tgt;
      rsp_pc_d = redirect_tgt;
      drop_d   = outst_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_VEC;
      rsp_pc_q <= RESET_VEC;
      outst_q  <= '0;
      drop_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
    end
  end

  assign push_entry = '{inst: im_rsp_data, pc: ENTRY_PC_W'(rsp_pc_q), pred_taken: pred_taken};

  fetch_fifo #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (id_valid && id_ready),
    .flush     (redirect_valid),
    .head      (head),
    .count     (fifo_count)
  );

  assign id_valid      = (fifo_count != '0);
  assign id_inst       = id_valid ? head.inst : NOP;
  assign id_pc         = id_valid ? XLEN'(head.pc) : '0;
  assign id_pc4        = id_valid ? XLEN'(head.pc) + XLEN'(4) : '0;
  assign id_pred_taken = id_valid && head.pred_taken;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the pipelined RISC-V core. It replaces the single-register PC/IF-ID pair with the following:
- a decoupled request/response instruction-memory port that supports multiple outstanding requests;
- a prefetch queue of configurable depth feeding decode through a valid/ready handshake;
- a redirect input from the branch-resolution stage;
- optional static branch prediction.

It sits between instruction memory and the ID stage.

## Interface
Parameters:
- XLEN, 32: PC and address width.
- RESET_VEC, 32'h1000_0000: first fetch address after reset.
- DEPTH, 4: prefetch queue entries. Power of two, ≥2. Also bounds outstanding requests.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- im_req_valid  out  1  fetch request valid.
- im_req_ready  in  1  IM accepts request.
- im_req_addr  out  XLEN  word-aligned fetch address.
- im_rsp_valid  in  1  instruction word returned, in request order, never earlier than the cycle after acceptance.
- im_rsp_data  in  32  instruction word.
- redirect_valid  in  1  pipeline redirect (taken branch/jump/mispredict).
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored.
- id_valid  out  1  queue head valid.
- id_ready  in  1  decode consumes head.
- id_inst  out  32  head instruction.
- id_pc  out  XLEN  head PC.
- id_pc4  out  XLEN  head PC + 4.
- id_pred_taken  out  1  head was predicted taken.

## Operation
- **Fetch PC register.** Issue rule: im_req_valid = 1 when (outst + count) < DEPTH, where outst is in-flight requests and count is queue occupancy.
  - On handshake (valid & ready): outst++ and PC += 4.
  - Because of the issue rule, responses are never back-pressured.
- **Response.**
  - If drop_cnt > 0: the word is discarded and drop_cnt--.
  - Otherwise: write {inst, pc, pred} to the queue tail. The pc comes from an internal in-flight PC FIFO or a tail-PC register.
  - In both cases outst--.
- **Queue.** id_* are driven from the head. A pop occurs when id_valid & id_ready.
  - Simultaneous push and pop on a full queue is legal; count is unchanged.
  - Push and pop on an empty queue: the pushed entry becomes visible next cycle.
- **Redirect** (highest priority):
  - The queue is flushed (count = 0, so no pop takes effect).
  - PC = {redirect_pc[XLEN-1:2], 2'b00}.
  - drop_cnt = outst plus any request accepted this cycle, minus any response returning this cycle.
  - A response arriving in the redirect cycle is dropped.
  - im_req_valid has no combinational dependence on redirect_valid. A request accepted in the redirect cycle carries the old PC and is dropped later.
- **Counters.**
  - outst and drop_cnt are $clog2(DEPTH+1) bits wide and never exceed DEPTH.
  - PC wraps modulo 2^XLEN.

## Timing
- **Reset values.**
  - While rst is low: im_req_valid=0, id_valid=0, im_req_addr=RESET_VEC, id_inst=32'h0000_0013 (NOP), id_pc=0, id_pc4=0, id_pred_taken=0.
  - PC=RESET_VEC, and all counters are 0.
- **First request.** Asserted in the first cycle after rst rises, with address RESET_VEC.
- **Latency.**
  - A response in cycle N appears at id_* in cycle N+1.
  - After a redirect in cycle N, the first request for redirect_pc is issued no earlier than cycle N+1.
- **Throughput.** One instruction per cycle, given single-cycle IM and id_ready held high.
- **Reset mid-operation.** All state is cleared asynchronously and in-flight responses are forgotten. IM must also reset.

## Configuration
- **FETCH_BPRED_EN defined:** each accepted response is pre-decoded.
  - Predicted taken: JAL, or B-type with imm sign = 1 (backward).
  - Target = pc + sign-extended imm.
  - On a predicted-taken response: PC = target, drop_cnt = remaining outst, and the entry is pushed with pred=1.
  - An external redirect in the same cycle overrides the prediction.
- **FETCH_BPRED_EN undefined:** purely sequential fetch; id_pred_taken is tied to 0.

## Structure
- **Package fetch_pkg:**
  - opcode constants OP_JAL=7'b1101111, OP_BRANCH=7'b1100011;
  - NOP constant;
  - typedef fetch_entry_t {inst, pc, pred_taken};
  - B/J immediate extraction functions.
- **Sub-module fetch_fifo:** parametrised-depth FIFO of fetch_entry_t with push, pop, flush, count.

## Test plan
- **Reset and streaming.** Reset, single-cycle IM, id_ready=1 → requests to 0x1000_0000, 0x1000_0004, …; id_pc sequential; id_pc4 = id_pc+4; one instruction per cycle.
- **Back-pressure.**
  - id_ready=0 with DEPTH=4 → at most 4 requests issued, then im_req_valid=0.
  - Release id_ready → drains in order with no loss.
- **Redirect with in-flight responses.** 2-cycle IM latency; redirect_pc=0x1000_0100 while 2 requests are outstanding → both stale responses dropped; next id_pc=0x1000_0100.
- **Simultaneous events.** Redirect in the same cycle as a response and as a pop → queue empty next cycle, response dropped, no underflow; count=0.
- **Prediction (FETCH_BPRED_EN).**
  - BEQ at 0x1000_0008 with imm=-8 → next request 0x1000_0000 and id_pred_taken=1.
  - Without the macro → next request 0x1000_000C.
- **Async reset mid-fetch.** Assert rst low with 3 outstanding → outputs reach reset values immediately; refetch starts at RESET_VEC.
